// File: rtl/axi4_pkg.sv
// Shared encodings for the AXI4 slave memory slice.
// Contents: burst and response encodings, the write and read FSM state types,
// and the burst-legality helper used at both address handshakes.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    // Whole-burst error: reserved burst type, unsupported size, illegal wrap
    // length, or an externally injected fault.
    function automatic logic burst_bad(input logic [1:0] burst,
                                       input logic       size_ok,
                                       input logic       wrap_ok,
                                       input logic       inj);
        return (burst == 2'b11) || !size_ok ||
               ((burst == BURST_WRAP) && !wrap_ok) || inj;
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-address generator for one AXI4 channel.
// Ports:
//   addr      in  current beat byte address
//   len       in  burst length in beats (awlen/arlen + 1)
//   burst     in  burst type (FIXED/INCR/WRAP)
//   next_addr out address of the following beat
//   wrap_ok   out len is a legal WRAP length (2, 4, 8 or 16)
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BYTES      = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [8:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  wrap_ok
);

    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] incr;

    always_comb begin
        mask = ADDR_WIDTH'(len) * ADDR_WIDTH'(BYTES) - ADDR_WIDTH'(1);
        incr = addr + ADDR_WIDTH'(BYTES);
        case (burst)
            BURST_INCR: next_addr = incr;
            // Upper bits pin the wrap window, lower bits advance inside it.
            BURST_WRAP: next_addr = (addr & ~mask) | (incr & mask);
            default:    next_addr = addr;
        endcase
        wrap_ok = (len == 9'd2) || (len == 9'd4) || (len == 9'd8) || (len == 9'd16);
    end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory responder: independent write and read FSMs over one
// word array, with INCR/WRAP/FIXED bursts and per-burst SLVERR reporting.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   inj_wr_err / inj_rd_err      force SLVERR for the burst at AW / AR handshake
//   aw*, w*, b*                  write address, data and response channels
//   ar*, r*                      read address and data channels
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inj_wr_err,
    input  logic                  inj_rd_err,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rlast,
    output logic [1:0]            rresp
);

    localparam int         BYTES   = DATA_WIDTH / 8;
    localparam int         LB      = $clog2(BYTES);
    localparam int         IW      = $clog2(MEM_DEPTH);
    localparam logic [2:0] SIZE_OK = 3'(LB);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> LB) < ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    // ---------------- write path ----------------
    wr_state_t             w_state;
    logic [ADDR_WIDTH-1:0] w_addr, w_next, wg_addr;
    logic [8:0]            w_len, w_beat, wg_len;
    logic [1:0]            w_burst, wg_burst;
    logic                  w_bad, w_err, wg_wrap_ok;
    logic                  w_hs, w_in_len, w_beat_err, mem_we;

    // In IDLE the generator sees the incoming AW fields so the wrap-length
    // check is available at the handshake; otherwise it walks the burst.
    always_comb begin
        wg_addr  = w_addr;
        wg_len   = w_len;
        wg_burst = w_burst;
        if (w_state == W_IDLE) begin
            wg_addr  = awaddr;
            wg_len   = {1'b0, awlen} + 9'd1;
            wg_burst = awburst;
        end
        w_hs       = wvalid && wready;
        w_in_len   = w_beat < w_len;
        w_beat_err = !in_range(w_addr) || !w_in_len ||
                     (wlast && (w_beat != w_len - 9'd1));
        mem_we     = w_hs && !w_bad && w_in_len && in_range(w_addr);
    end

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES)) u_wr_gen (
        .addr      (wg_addr),
        .len       (wg_len),
        .burst     (wg_burst),
        .next_addr (w_next),
        .wrap_ok   (wg_wrap_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_burst <= '0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_addr  <= awaddr;
                        w_len   <= wg_len;
                        w_burst <= awburst;
                        w_beat  <= '0;
                        w_err   <= 1'b0;
                        w_bad   <= burst_bad(awburst, awsize == SIZE_OK, wg_wrap_ok, inj_wr_err);
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_addr <= w_next;
                        // Saturate so an overlong burst never aliases back into range.
                        if (w_beat != '1) w_beat <= w_beat + 9'd1;
                        w_err <= w_err | w_beat_err;
                        if (wlast) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (w_bad || w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[w_addr[LB +: IW]] <= wdata;
    end

    // ---------------- read path ----------------
    rd_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_addr, r_next, rg_addr, ld_addr;
    logic [8:0]            r_len, r_beat, rg_len;
    logic [1:0]            r_burst, rg_burst;
    logic                  r_bad, rg_wrap_ok, ar_bad, ld_ok;

    always_comb begin
        rg_addr  = r_addr;
        rg_len   = r_len;
        rg_burst = r_burst;
        if (r_state == R_IDLE) begin
            rg_addr  = araddr;
            rg_len   = {1'b0, arlen} + 9'd1;
            rg_burst = arburst;
        end
        ar_bad  = burst_bad(arburst, arsize == SIZE_OK, rg_wrap_ok, inj_rd_err);
        // Beat to load: beat 0 at the AR handshake, else the following beat.
        ld_addr = (r_state == R_IDLE) ? araddr : r_next;
        ld_ok   = !((r_state == R_IDLE) ? ar_bad : r_bad) && in_range(ld_addr);
    end

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES)) u_rd_gen (
        .addr      (rg_addr),
        .len       (rg_len),
        .burst     (rg_burst),
        .next_addr (r_next),
        .wrap_ok   (rg_wrap_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready <= 1'b0;
                        r_addr  <= araddr;
                        r_len   <= rg_len;
                        r_burst <= arburst;
                        r_beat  <= '0;
                        r_bad   <= ar_bad;
                        rvalid  <= 1'b1;
                        rdata   <= ld_ok ? mem[ld_addr[LB +: IW]] : '0;
                        rresp   <= ld_ok ? RESP_OKAY : RESP_SLVERR;
                        rlast   <= (arlen == 8'd0);
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_next;
                            r_beat <= r_beat + 9'd1;
                            rdata  <= ld_ok ? mem[ld_addr[LB +: IW]] : '0;
                            rresp  <= ld_ok ? RESP_OKAY : RESP_SLVERR;
                            rlast  <= (r_beat + 9'd1) == (r_len - 9'd1);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Self-checking bench for axi4_slave_mem: expected B responses and R beats
// are queued when a burst is issued and compared as the DUT returns them.
module tb_axi4_slave_mem;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inj_wr_err, inj_rd_err;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [63:0] wdata;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [63:0] rdata;
    logic        rlast;
    logic [1:0]  rresp;

    always #5 clk = ~clk;

    axi4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .inj_wr_err(inj_wr_err), .inj_rd_err(inj_rd_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    logic [63:0] mdl [int];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
        logic [31:0] m;
        m = (32'(l) + 32'd1) * 32'd8 - 32'd1;
        case (b)
            2'b01:   return a + 32'd8;
            2'b10:   return (a & ~m) | ((a + 32'd8) & m);
            default: return a;
        endcase
    endfunction

    function automatic logic is_bad(input logic [7:0] l, input logic [1:0] b, input logic inj);
        return (b == 2'b11) || (b == 2'b10 && !(l inside {8'd1, 8'd3, 8'd7, 8'd15})) || inj;
    endfunction

    task automatic chk_reset_outputs();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic inj);
        int n = 0;
        awaddr = a; awlen = l; awburst = b; awsize = 3'd3; inj_wr_err = inj; awvalid = 1'b1;
        while (!awready && n < TMO) begin @(negedge clk); n++; end
        check("aw_handshake", n < TMO, 1);
        @(negedge clk);
        awvalid = 1'b0; inj_wr_err = 1'b0;
        check("wready_after_aw", wready, 1);
        check("awready_after_aw", awready, 0);
    endtask

    task automatic w_beat(input logic [63:0] d, input logic last);
        int n = 0;
        wdata = d; wlast = last; wvalid = 1'b1;
        while (!wready && n < TMO) begin @(negedge clk); n++; end
        check("w_handshake", n < TMO, 1);
        @(negedge clk);
    endtask

    task automatic w_send(input logic [63:0] base, input int nb);
        for (int i = 0; i < nb; i++) w_beat(base + 64'(i), i == nb - 1);
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid_after_wlast", bvalid, 1);
        check("wready_after_wlast", wready, 0);
    endtask

    task automatic b_recv(input int hold);
        int n = 0;
        bready = 1'b0;
        while (!bvalid && n < TMO) begin @(negedge clk); n++; end
        check("b_wait", n < TMO, 1);
        repeat (hold) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, bq[0]);
            check("awready_during_b", awready, 0);
        end
        bready = 1'b1;
        check("bresp", bresp, bq.pop_front());
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_fall", bvalid, 0);
    endtask

    task automatic wr_burst(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                            input logic inj, input int nb, input logic [63:0] base, input int hold);
        logic        bad, err;
        logic [31:0] x;
        bad = is_bad(l, b, inj);
        err = (nb != int'(l) + 1);
        x   = a;
        for (int i = 0; i < nb; i++) begin
            if (i > int'(l) || (x >> 3) >= 32'd1024) err = 1'b1;
            else if (!bad) mdl[int'(x >> 3)] = base + 64'(i);
            x = nxt(x, l, b);
        end
        bq.push_back((bad || err) ? 2'b10 : 2'b00);
        aw_send(a, l, b, inj);
        w_send(base, nb);
        b_recv(hold);
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic inj);
        int n = 0;
        araddr = a; arlen = l; arburst = b; arsize = 3'd3; inj_rd_err = inj; arvalid = 1'b1;
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        check("ar_handshake", n < TMO, 1);
        @(negedge clk);
        arvalid = 1'b0; inj_rd_err = 1'b0;
        check("rvalid_after_ar", rvalid, 1);
    endtask

    task automatic r_recv(input logic toggle);
        int     n = 0;
        logic   done = 1'b0;
        rbeat_t e;
        while (!done && n < TMO) begin
            rready = toggle ? n[0] : 1'b1;
            if (rvalid && rready) begin
                if (rq.size() == 0) check("r_extra_beat", 1, 0);
                else begin
                    e = rq.pop_front();
                    check("rdata", rdata, e.data);
                    check("rresp", rresp, e.resp);
                    check("rlast", rlast, e.last);
                end
                done = rlast;
            end else if (rvalid && rq.size() > 0) begin
                check("rdata_hold", rdata, rq[0].data);
                check("rlast_hold", rlast, rq[0].last);
                check("arready_during_r", arready, 0);
            end
            @(negedge clk);
            n++;
        end
        rready = 1'b0;
        check("r_done", done, 1);
        check("r_beats_left", rq.size(), 0);
        check("rvalid_fall", rvalid, 0);
    endtask

    task automatic rd_burst(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                            input logic inj, input logic toggle);
        logic        bad;
        logic [31:0] x;
        rbeat_t      e;
        bad = is_bad(l, b, inj);
        x   = a;
        for (int i = 0; i <= int'(l); i++) begin
            e.last = (i == int'(l));
            if (bad || (x >> 3) >= 32'd1024) begin
                e.data = '0; e.resp = 2'b10;
            end else begin
                e.data = mdl[int'(x >> 3)]; e.resp = 2'b00;
            end
            rq.push_back(e);
            x = nxt(x, l, b);
        end
        ar_send(a, l, b, inj);
        r_recv(toggle);
    endtask

    initial begin
        rst_n = 1'b1;
        inj_wr_err = 0; inj_rd_err = 0;
        awvalid = 0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        wvalid = 0; wdata = '0; wlast = 0; bready = 0;
        arvalid = 0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; rready = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("awready_after_reset", awready, 1);
        check("arready_after_reset", arready, 1);

        // INCR write then read back
        wr_burst(32'h100, 8'd3, 2'b01, 1'b0, 4, 64'hA0, 0);
        rd_burst(32'h100, 8'd3, 2'b01, 1'b0, 1'b0);
        // WRAP read starting mid-window
        rd_burst(32'h118, 8'd3, 2'b10, 1'b0, 1'b0);
        // out-of-range write must not alias onto word 0
        wr_burst(32'h0, 8'd0, 2'b01, 1'b0, 1, 64'h55, 0);
        wr_burst(32'h2000, 8'd0, 2'b01, 1'b0, 1, 64'hBAD0, 0);
        rd_burst(32'h0, 8'd0, 2'b01, 1'b0, 1'b0);
        // illegal wrap length writes nothing
        wr_burst(32'h200, 8'd2, 2'b01, 1'b0, 3, 64'hC0, 0);
        wr_burst(32'h200, 8'd2, 2'b10, 1'b0, 3, 64'hD0, 0);
        rd_burst(32'h200, 8'd2, 2'b01, 1'b0, 1'b0);
        // injected write fault then clean retry
        wr_burst(32'h300, 8'd1, 2'b01, 1'b0, 2, 64'hF0, 0);
        wr_burst(32'h300, 8'd1, 2'b01, 1'b1, 2, 64'hE0, 0);
        rd_burst(32'h300, 8'd1, 2'b01, 1'b0, 1'b0);
        wr_burst(32'h300, 8'd1, 2'b01, 1'b0, 2, 64'hE0, 0);
        rd_burst(32'h300, 8'd1, 2'b01, 1'b0, 1'b0);
        // B backpressure and R toggled ready
        wr_burst(32'h400, 8'd0, 2'b01, 1'b0, 1, 64'h77, 5);
        rd_burst(32'h100, 8'd3, 2'b01, 1'b0, 1'b1);
        // wlast early / late
        wr_burst(32'h600, 8'd3, 2'b01, 1'b0, 2, 64'h60, 0);
        wr_burst(32'h680, 8'd1, 2'b01, 1'b0, 3, 64'h68, 0);
        rd_burst(32'h600, 8'd1, 2'b01, 1'b0, 1'b0);
        rd_burst(32'h680, 8'd1, 2'b01, 1'b0, 1'b0);
        // read errors: reserved burst, injected fault, out of range
        rd_burst(32'h100, 8'd1, 2'b11, 1'b0, 1'b0);
        rd_burst(32'h100, 8'd1, 2'b01, 1'b1, 1'b0);
        rd_burst(32'h2000, 8'd0, 2'b01, 1'b0, 1'b0);

        // reset during beat 2 of a 4-beat write; beats 0 and 1 stay written
        mdl[32'h500 >> 3]       = 64'h50;
        mdl[(32'h500 >> 3) + 1] = 64'h51;
        aw_send(32'h500, 8'd3, 2'b01, 1'b0);
        w_beat(64'h50, 1'b0);
        w_beat(64'h51, 1'b0);
        wdata = 64'h52; wlast = 1'b0; wvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_burst(32'h500, 8'd1, 2'b01, 1'b0, 1'b0);
        wr_burst(32'h500, 8'd3, 2'b01, 1'b0, 4, 64'h90, 0);
        rd_burst(32'h500, 8'd3, 2'b01, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
